// File: rtl/mul_sequencer.sv
// Request sequencer for the shift-add multiplier: request FIFO, operand magnitudes, Run/Ready control, sign fix.
// Define MULSEQ_SIGNED_EN to honour in_signed (two's-complement operands); otherwise operands are unsigned.
module mul_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD      = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_signed,
  output logic        mul_Run,
  output logic [31:0] mul_Multiplier,
  output logic [31:0] mul_Multiplicand,
  input  logic [63:0] mul_Product,
  input  logic        mul_Ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        out_err,
  output logic        busy
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int TM1 = TIMEOUT - 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] GUARD_C  = GUARD[CW-1:0];
  localparam logic [CW-1:0] LAST_C   = TM1[CW-1:0];

`ifdef MULSEQ_SIGNED_EN
  typedef struct packed { logic [31:0] a; logic [31:0] b; logic sgn; } req_t;
`else
  typedef struct packed { logic [31:0] a; logic [31:0] b; } req_t;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FIX, OUT} state_t;

  state_t        state, state_nxt;
  req_t          fifo_mem [FIFO_DEPTH];
  req_t          wr_req, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, neg, neg_nxt, take, tmo;
  logic [31:0]   mag_a, mag_b;
  logic [CW-1:0] wcnt;

  // No push-through: a full FIFO refuses even when the head pops this cycle.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) & (count != '0);
  assign head     = fifo_mem[rd_ptr];

`ifdef MULSEQ_SIGNED_EN
  assign wr_req  = '{a: in_a, b: in_b, sgn: in_signed};
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a   = (head.sgn & head.a[31]) ? (32'd0 - head.a) : head.a;
  assign mag_b   = (head.sgn & head.b[31]) ? (32'd0 - head.b) : head.b;
  assign neg_nxt = head.sgn & (head.a[31] ^ head.b[31]);
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign wr_req  = '{a: in_a, b: in_b};
  assign mag_a   = head.a;
  assign mag_b   = head.b;
  assign neg_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_req;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Ready is only trusted after the guard window; it wins over a same-cycle timeout.
  assign take = (state == WAIT) & (wcnt >= GUARD_C) & mul_Ready;
  assign tmo  = (state == WAIT) & ~take & (wcnt == LAST_C);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (take) state_nxt = FIX;
               else if (tmo) state_nxt = OUT;
      FIX:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_Run   = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE) | (count != '0);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mul_Multiplier   <= '0;
      mul_Multiplicand <= '0;
      neg              <= 1'b0;
      wcnt             <= '0;
      out_product      <= '0;
      out_err          <= 1'b0;
    end else begin
      if (pop) begin
        mul_Multiplier   <= mag_a;
        mul_Multiplicand <= mag_b;
        neg              <= neg_nxt;
      end
      if (state == LOAD)      wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 1'b1;
      if (state == FIX) begin
        out_product <= neg ? (~mul_Product + 64'd1) : mul_Product;
        out_err     <= 1'b0;
      end else if (tmo) begin
        out_product <= '0;
        out_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: request-level scoreboard plus a behavioural multiplier.
// Follows MULSEQ_SIGNED_EN the same way the design does.
`timescale 1ns/1ps
module tb_mul_sequencer;
  localparam int DEPTH   = 4;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 64;
`ifdef MULSEQ_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid, in_signed, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, mul_Run, out_valid, out_err, busy;
  logic [31:0] mul_Multiplier, mul_Multiplicand;
  logic [63:0] out_product;
  logic        mul_Ready = 1'b0;
  logic [63:0] mul_Product = '0;

  mul_sequencer #(.FIFO_DEPTH(DEPTH), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .mul_Run(mul_Run), .mul_Multiplier(mul_Multiplier), .mul_Multiplicand(mul_Multiplicand),
    .mul_Product(mul_Product), .mul_Ready(mul_Ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] a; logic [31:0] b; logic s; int pc; } req_t;
  req_t q[$];
  req_t cur;

  int npass = 0, ntot = 0;
  int r_mode = 0, r_fix = 5;          // 0 fixed R, 1 Ready never, 2 stale Ready, 3 random
  logic in_flight = 1'b0, exp_run, ev, exp_err, act = 1'b0, ov_prev = 1'b0;
  logic cur_tie = 1'b0, cur_stale = 1'b0;
  int   cur_r = 0, widx = 0, free_cyc = 0, exp_out_cyc = 0, dut_run_cyc = 0, nrun = 0, last_lat = 0;
  logic [63:0] exp_pv, pend, last_prod;
  logic        last_err;
  logic [31:0] last_mag_a, last_mag_b;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    ntot++;
    if (act_v === exp_v) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act_v, exp_v, cyc);
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [31:0] exp_mag(input logic [31:0] v, input logic s);
    return (SEN && s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return (SEN && s) ? 64'(x * y) : ({32'd0, a} * {32'd0, b});
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard, multiplier model and per-cycle compare, all at the negedge.
  always @(negedge clk) begin
    if (!Reset) begin
      q.delete();
      in_flight = 1'b0;
      act       = 1'b0;
      mul_Ready = 1'b0;
      ov_prev   = 1'b0;
      free_cyc  = cyc + 1;
    end else begin
      // Head becomes visible the cycle after its push; IDLE pops it, Run follows.
      exp_run = !in_flight && q.size() > 0 && cyc == imax(free_cyc, q[0].pc + 1) + 1;
      chk("mul_Run", 64'(mul_Run), 64'(exp_run));
      if (mul_Run) begin
        nrun++;
        dut_run_cyc = cyc;
        last_mag_a  = mul_Multiplier;
        last_mag_b  = mul_Multiplicand;
      end
      if (exp_run) begin
        cur = q.pop_front();
        in_flight = 1'b1;
        chk("mul_Multiplier", 64'(mul_Multiplier), 64'(exp_mag(cur.a, cur.s)));
        chk("mul_Multiplicand", 64'(mul_Multiplicand), 64'(exp_mag(cur.b, cur.s)));
        cur_tie   = (r_mode == 1) || (r_mode == 3 && $urandom_range(0, 7) == 0);
        cur_stale = (r_mode == 2);
        cur_r     = (r_mode == 3) ? int'($urandom_range(0, 45)) : r_fix;
        if (cur_tie || imax(GUARD, cur_r) > TIMEOUT - 1) begin
          exp_err = 1'b1; exp_pv = '0; exp_out_cyc = cyc + TIMEOUT + 1;
        end else begin
          exp_err = 1'b0; exp_pv = exp_prod(cur.a, cur.b, cur.s);
          exp_out_cyc = cyc + imax(GUARD, cur_r) + 1 + 2;
        end
      end
      // Multiplier: Ready rises in the cycle R cycles after the Run cycle ends.
      if (mul_Run) begin
        act  = 1'b1;
        widx = -1;
        pend = {32'd0, mul_Multiplier} * {32'd0, mul_Multiplicand};
        if (!cur_stale) mul_Ready = 1'b0;
      end else if (act) begin
        widx++;
        if (!cur_tie && widx == cur_r) begin
          mul_Ready = 1'b1; mul_Product = pend; act = 1'b0;
        end else if (cur_stale && widx == GUARD) begin
          mul_Ready = 1'b0;
        end
      end
      ev = in_flight && cyc >= exp_out_cyc;
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
        chk("out_product", out_product, exp_pv);
        chk("out_err", 64'(out_err), 64'(exp_err));
      end
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("busy", 64'(busy), 64'(in_flight || q.size() != 0));
      if (out_valid && !ov_prev) last_lat = cyc - dut_run_cyc + 1;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin last_prod = out_product; last_err = out_err; end
      if (ev && out_ready) begin in_flight = 1'b0; free_cyc = cyc + 1; end
      if (in_valid && q.size() < DEPTH) q.push_back('{in_a, in_b, in_signed, cyc});
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
    while (!in_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) chk("push_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || in_flight) && n < budget) begin @(posedge clk); n++; end
    if (n >= budget) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mul_Run"}, 64'(mul_Run), 64'd0);
    chk({tag, "_mul_Multiplier"}, 64'(mul_Multiplier), 64'd0);
    chk({tag, "_mul_Multiplicand"}, 64'(mul_Multiplicand), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_product"}, out_product, 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n0, n;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    Reset = 1'b1;

    // Unsigned 3*5 with Ready at R=33
    r_mode = 0; r_fix = 33;
    push(32'd3, 32'd5, 1'b0);
    drain(300);
    chk("t1_product", last_prod, 64'h0000_0000_0000_000F);
    chk("t1_err", 64'(last_err), 64'd0);
    chk("t1_latency", 64'(last_lat), 64'd37);

    // -3 * 5
    r_fix = 4;
    push(32'hFFFF_FFFD, 32'd5, 1'b1);
    drain(300);
    chk("t2_mag_a", 64'(last_mag_a), SEN ? 64'd3 : 64'hFFFF_FFFD);
    chk("t2_mag_b", 64'(last_mag_b), 64'd5);
    chk("t2_product", last_prod, SEN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);

    // Most-negative operands
    push(32'h8000_0000, 32'h8000_0000, 1'b1);
    drain(300);
    chk("t3_product", last_prod, 64'h4000_0000_0000_0000);

    // FIFO full with downstream stalled, then release
    out_ready = 1'b0; r_fix = 3;
    for (int i = 0; i < 5; i++) push(32'(i + 1), 32'(i + 10), 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("t4_in_ready_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    push(32'd6, 32'd15, 1'b0);
    drain(600);
    chk("t4_last_product", last_prod, 64'd90);

    // Timeout, then a normal request
    r_mode = 1;
    push(32'd7, 32'd9, 1'b0);
    drain(300);
    chk("t5_err", 64'(last_err), 64'd1);
    chk("t5_product", last_prod, 64'd0);
    r_mode = 0; r_fix = 10;
    push(32'd7, 32'd9, 1'b0);
    drain(300);
    chk("t5b_err", 64'(last_err), 64'd0);
    chk("t5b_product", last_prod, 64'd63);

    // Ready on the would-be timeout cycle
    r_fix = TIMEOUT - 1;
    push(32'd2, 32'd3, 1'b0);
    drain(300);
    chk("t6_err", 64'(last_err), 64'd0);
    chk("t6_product", last_prod, 64'd6);
    chk("t6_latency", 64'(last_lat), 64'(TIMEOUT + 3));

    // Stale Ready (and stale product 6) held through Run
    r_mode = 2; r_fix = GUARD + 3;
    push(32'd11, 32'd13, 1'b0);
    drain(300);
    chk("t7_product", last_prod, 64'd143);
    chk("t7_latency", 64'(last_lat), 64'(GUARD + 3 + 1 + 3));

    // Randomized traffic with random backpressure and Ready delays
    r_mode = 3;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) == 0);
      in_a      = pick();
      in_b      = pick();
      in_signed = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(3000);

    // Reset asserted mid-WAIT with entries queued
    r_mode = 0; r_fix = 30;
    push(32'd4, 32'd4, 1'b0);
    push(32'd5, 32'd5, 1'b0);
    push(32'd6, 32'd6, 1'b0);
    repeat (4) @(posedge clk);
    #1 Reset = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1 Reset = 1'b1;
    n0 = nrun;
    repeat (60) @(posedge clk);
    #1;
    chk("post_reset_runs", 64'(nrun - n0), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
